// File: rtl/counter.sv
// Free-running binary up/down counter, modulo 2^WIDTH, async active-low reset.
// Latency: up_count sampled at each rising edge, count is registered; no backpressure.
module counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_count,
  output logic [WIDTH-1:0] count
);

  // Carry and borrow fall off the top bit, which gives the wrap in both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (up_count) begin
      count <= count + 1'b1;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter at WIDTH = 4, 1 and 8 sharing one clock and control.
module tb_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_count;
  logic [3:0] c4;
  logic [0:0] c1;
  logic [7:0] c8;

  always #5 clk = ~clk;

  counter #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .up_count(up_count), .count(c4));
  counter #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .up_count(up_count), .count(c1));
  counter #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .up_count(up_count), .count(c8));

  int n_cmp = 0;
  int n_err = 0;
  int m4 = 0, m1 = 0, m8 = 0;
  int q4[$], q1[$], q8[$];

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp[31:0]) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int m, input int modulus, input logic rst, input logic up);
    int r;
    if (!rst) r = 0;
    else if (up) r = (m + 1) % modulus;
    else r = (m + modulus - 1) % modulus;
    return r;
  endfunction

  // Called just after a falling edge: drive inputs, predict the value after the
  // next rising edge, then compare on the following falling edge.
  task automatic step(input logic rst, input logic up, input string tag);
    rst_n    = rst;
    up_count = up;
    m4 = nxt(m4, 16, rst, up);
    m1 = nxt(m1, 2, rst, up);
    m8 = nxt(m8, 256, rst, up);
    q4.push_back(m4);
    q1.push_back(m1);
    q8.push_back(m8);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/w4"}, {28'd0, c4}, q4.pop_front());
    chk({tag, "/w1"}, {31'd0, c1}, q1.pop_front());
    chk({tag, "/w8"}, {24'd0, c8}, q8.pop_front());
  endtask

  // Reset asserted between edges must clear every instance before the next edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "/w4"}, {28'd0, c4}, 0);
    chk({tag, "/w1"}, {31'd0, c1}, 0);
    chk({tag, "/w8"}, {24'd0, c8}, 0);
    m4 = 0; m1 = 0; m8 = 0;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    up_count = 1'b1;
    @(negedge clk);
    chk("reset_state", {28'd0, c4}, 0);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "reset_hold");

    // Release at a falling edge: the next edge is the first count step.
    rst_n = 1'b1;
    #1;
    chk("release_pre", {28'd0, c4}, 0);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, "up_wrap");

    step(1'b0, 1'b0, "reset_before_down");
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, "down_wrap");

    step(1'b0, 1'b1, "reset_before_mid");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, "up_to_9");
    chk("at_9", {28'd0, c4}, 9);
    mid_reset("async_mid");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "resume");

    chk("at_5", {28'd0, c4}, 5);
    step(1'b1, 1'b1, "rev_last_up");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reverse");
    chk("after_reverse", {28'd0, c4}, 3);

    step(1'b0, 1'b1, "reset_before_w8up");
    for (int i = 0; i < 258; i++) step(1'b1, 1'b1, "w8_up_wrap");

    step(1'b0, 1'b0, "reset_before_w8down");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "w8_down_wrap");
    chk("w8_down_fd", {24'd0, c8}, 8'hFD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
